inst_encoder: RTL and testbench

//  Packs decoded RV32I fields (opcode class, regs, funct, 32-bit immediate) into 32-bit instruction words.

---
 rtl/inst_encoder.sv | 185 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
// inst_encoder: packs decoded RV32I field bundles into 32-bit instruction words
// paired with an auto-incrementing imem byte address, via a two-stage valid/ready pipeline.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_addr,
    output logic        o_err,
    output logic [15:0] o_err_cnt
);

    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_REG    = 5'b01100;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

    logic        s1_valid;
    logic [4:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_inst;
    logic        s2_err;

    logic [31:0] addr_q;
    logic [15:0] err_cnt_q;

    logic        in_fire;
    logic        out_fire;
    logic        s1_advance;

    logic        fits_12;
    logic        fits_b;
    logic        fits_j;
    logic        lui_aligned;
    logic        enc_legal;
    logic [24:0] enc_body;
    logic [31:0] enc_inst;

    // S1 may move into S2 whenever S2 is empty or is handing its word off this cycle.
    assign out_fire   = s2_valid && i_ready;
    assign s1_advance = s1_valid && (!s2_valid || i_ready);
    assign o_ready    = !i_flush && (!s1_valid || s1_advance);
    assign in_fire    = i_valid && o_ready;

    // A value fits a signed N-bit field when every bit above the sign bit repeats it.
    assign fits_12     = (s1_imm[31:11] == {21{s1_imm[11]}});
    assign fits_b      = (s1_imm[31:12] == {20{s1_imm[12]}}) && !s1_imm[0];
    assign fits_j      = (s1_imm[31:20] == {12{s1_imm[20]}}) && !s1_imm[0];
    assign lui_aligned = (s1_imm[11:0] == 12'd0);

    always_comb begin
        enc_legal = 1'b0;
        enc_body  = '0;
        case (s1_op)
            OP_IMM, OP_LOAD, OP_JALR: begin
                enc_legal = fits_12;
                enc_body  = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd};
            end
            OP_STORE: begin
                enc_legal = fits_12;
                enc_body  = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0]};
            end
            OP_BRANCH: begin
                enc_legal = fits_b;
                enc_body  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11]};
            end
            OP_JAL: begin
                enc_legal = fits_j;
                enc_body  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd};
            end
            OP_LUI, OP_AUIPC: begin
                enc_legal = lui_aligned;
                enc_body  = {s1_imm[31:12], s1_rd};
            end
            OP_REG: begin
                enc_legal = 1'b1;
                enc_body  = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd};
            end
            default: begin
                enc_legal = 1'b0;
                enc_body  = '0;
            end
        endcase
        enc_inst = enc_legal ? {enc_body, s1_op, 2'b11} : NOP_INST;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_op     <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else if (in_fire) begin
            s1_op     <= i_op;
            s1_rd     <= i_rd;
            s1_rs1    <= i_rs1;
            s1_rs2    <= i_rs2;
            s1_funct3 <= i_funct3;
            s1_funct7 <= i_funct7;
            s1_imm    <= i_imm;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_inst  <= '0;
            s2_err   <= 1'b0;
        end else if (i_flush) begin
            s2_valid <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= 1'b1;
            s2_inst  <= enc_inst;
            s2_err   <= !enc_legal;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    // Flush rewinds the address but deliberately keeps the illegal-bundle count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
        end else if (i_flush) begin
            addr_q <= BASE_ADDR;
        end else if (out_fire) begin
            addr_q <= (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
            if (s2_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_valid   = s2_valid;
    assign o_inst    = s2_inst;
    assign o_err     = s2_err;
    assign o_addr    = addr_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
// tb_inst_encoder: table vectors, hand-written pipeline sequences and random bundles,
// all checked by a scoreboard fed from a field-level encoding model.
module tb_inst_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [4:0] I_OP = 5'b00100, LD_OP = 5'b00000, JR_OP = 5'b11001;
    localparam logic [4:0] S_OP = 5'b01000, B_OP = 5'b11000, J_OP = 5'b11011;
    localparam logic [4:0] LUI_OP = 5'b01101, AUI_OP = 5'b00101, R_OP = 5'b01100;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_op = '0, i_rd = '0, i_rs1 = '0, i_rs2 = '0;
    logic [2:0]  i_funct3 = '0;
    logic [6:0]  i_funct7 = '0;
    logic [31:0] i_imm = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_inst, o_addr;
    logic        o_err;
    logic [15:0] o_err_cnt;

    typedef struct {
        logic [4:0]  op, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc_edge;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          check_cnt = 0;
    int          fail_cnt = 0;
    int          edge_cnt = 0;
    int          out_cnt = 0;
    int          accept_cnt = 0;
    logic [15:0] err_model = '0;
    logic [31:0] drv_inst = '0;
    logic        drv_err = 1'b0;
    bit          rand_ready = 1'b0;
    int          bounds[14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                                -4097, -4098, 1048574, 1048576, -1048576, -1048578};

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm), .o_valid(o_valid),
        .i_ready(i_ready), .o_inst(o_inst), .o_addr(o_addr), .o_err(o_err),
        .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edge_cnt++;

    always @(posedge i_clk) begin
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Encoding rules written as arithmetic on the immediate's numeric value.
    function automatic logic [32:0] ref_encode(input vec_t v);
        int          s;
        int unsigned u, w, opc, rdp, regs;
        bit          legal;
        s     = v.imm;
        u     = v.imm;
        opc   = 32'(v.op) * 4 + 3;
        rdp   = 32'(v.rd) << 7;
        regs  = (32'(v.rs2) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12);
        legal = 1'b0;
        w     = 0;
        case (v.op)
            I_OP, LD_OP, JR_OP: begin
                legal = (s >= -2048) && (s <= 2047);
                w = ((u & 32'hfff) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | rdp | opc;
            end
            S_OP: begin
                legal = (s >= -2048) && (s <= 2047);
                w = (((u >> 5) & 32'h7f) << 25) | regs | ((u & 32'h1f) << 7) | opc;
            end
            B_OP: begin
                legal = (s >= -4096) && (s <= 4094) && ((u & 1) == 0);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | regs |
                    (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | opc;
            end
            J_OP: begin
                legal = (s >= -1048576) && (s <= 1048574) && ((u & 1) == 0);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | rdp | opc;
            end
            LUI_OP, AUI_OP: begin
                legal = (u % 4096) == 0;
                w = (u & 32'hfffff000) | rdp | opc;
            end
            R_OP: begin
                legal = 1'b1;
                w = (32'(v.f7) << 25) | regs | rdp | opc;
            end
            default: legal = 1'b0;
        endcase
        return legal ? {1'b0, w} : {1'b1, NOP};
    endfunction

    function automatic vec_t mkv(input logic [4:0] op, rd, rs1, rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm,
                                 input logic [31:0] inst, input logic err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.inst = inst; v.err = err;
        return v;
    endfunction

    // Scoreboard: occupancy predicts o_ready, accept edge predicts o_valid, word count predicts o_addr.
    always @(negedge i_clk) begin
        bit   exp_valid;
        exp_t e;
        if (i_reset) begin
            sb.delete();
            out_cnt   = 0;
            err_model = '0;
        end else begin
            exp_valid = (sb.size() > 0) && (edge_cnt >= sb[0].acc_edge + 1);
            checkOutput("o_valid", o_valid, exp_valid);
            checkOutput("o_ready", o_ready, !i_flush && ((sb.size() < 2) || i_ready));
            checkOutput("o_err_cnt", o_err_cnt, err_model);
            checkOutput("o_addr", o_addr, BASE + 32'(4 * (out_cnt % DEPTH)));
            if (i_flush) begin
                sb.delete();
                out_cnt = 0;
            end else begin
                if (exp_valid && i_ready) begin
                    e = sb.pop_front();
                    checkOutput("o_inst", o_inst, e.inst);
                    checkOutput("o_err", o_err, e.err);
                    if (e.err && err_model != 16'hFFFF) err_model++;
                    out_cnt++;
                end
                if (i_valid && o_ready) begin
                    e.inst = drv_inst;
                    e.err = drv_err;
                    e.acc_edge = edge_cnt + 1;
                    sb.push_back(e);
                    accept_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic driveFields(input vec_t v);
        i_op = v.op; i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2;
        i_funct3 = v.f3; i_funct7 = v.f7; i_imm = v.imm;
        drv_inst = v.inst; drv_err = v.err;
    endtask

    task automatic applyStimulus(input vec_t v);
        int waited = 0;
        driveFields(v);
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) begin
            check_cnt++;
            fail_cnt++;
            $display("[TB] FAIL accept_timeout: o_ready stayed 0 for %0d cycles, required 1", waited);
        end
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        rand_ready = 1'b0;
        i_ready = 1'b1;
        while (sb.size() != 0 && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("drain_left", sb.size(), 0);
        step();
    endtask

    task automatic doFlush(input bit with_valid);
        if (with_valid) begin
            driveFields(vecs[0]);
            i_valid = 1'b1;
        end
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] randImm();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 8191)) - 32'd4096;
            1: return 32'(bounds[$urandom_range(0, 13)]);
            2: return $urandom;
            3: return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        logic [4:0]  ops[9] = '{I_OP, LD_OP, JR_OP, S_OP, B_OP, J_OP, LUI_OP, AUI_OP, R_OP};
        logic [32:0] r;
        vec_t        v;
        int          start, idx;

        vecs.push_back(mkv(I_OP,   1, 0, 0, 0, 0,     32'd5,        32'h0050_0093, 0));
        vecs.push_back(mkv(S_OP,   0, 1, 2, 2, 0,     32'd8,        32'h0020_A423, 0));
        vecs.push_back(mkv(B_OP,   0, 0, 0, 0, 0,     32'hFFFF_FFFC, 32'hFE00_0EE3, 0));
        vecs.push_back(mkv(J_OP,   1, 0, 0, 0, 0,     32'd2048,     32'h0010_00EF, 0));
        vecs.push_back(mkv(B_OP,   0, 0, 0, 0, 0,     32'd3,        NOP,           1));
        vecs.push_back(mkv(I_OP,   0, 0, 0, 0, 0,     32'd2047,     32'h7FF0_0013, 0));
        vecs.push_back(mkv(I_OP,   0, 0, 0, 0, 0,     32'hFFFF_F800, 32'h8000_0013, 0));
        vecs.push_back(mkv(I_OP,   0, 0, 0, 0, 0,     32'd2048,     NOP,           1));
        vecs.push_back(mkv(LD_OP,  5, 6, 0, 2, 0,     32'hFFFF_FFFF, 32'hFFF3_2283, 0));
        vecs.push_back(mkv(S_OP,   0, 0, 0, 0, 0,     32'hFFFF_F7FF, NOP,           1));
        vecs.push_back(mkv(B_OP,   0, 1, 2, 1, 0,     32'd4094,     32'h7E20_9FE3, 0));
        vecs.push_back(mkv(B_OP,   0, 0, 0, 0, 0,     32'd4096,     NOP,           1));
        vecs.push_back(mkv(B_OP,   0, 0, 0, 0, 0,     32'hFFFF_F000, 32'h8000_0063, 0));
        vecs.push_back(mkv(B_OP,   0, 0, 0, 0, 0,     32'hFFFF_EFFE, NOP,           1));
        vecs.push_back(mkv(J_OP,   0, 0, 0, 0, 0,     32'hFFF0_0000, 32'h8000_006F, 0));
        vecs.push_back(mkv(J_OP,   0, 0, 0, 0, 0,     32'h0010_0000, NOP,           1));
        vecs.push_back(mkv(J_OP,   0, 0, 0, 0, 0,     32'h000F_FFFE, 32'h7FFF_F06F, 0));
        vecs.push_back(mkv(J_OP,   0, 0, 0, 0, 0,     32'd1,        NOP,           1));
        vecs.push_back(mkv(LUI_OP, 3, 0, 0, 0, 0,     32'h1234_5000, 32'h1234_51B7, 0));
        vecs.push_back(mkv(AUI_OP, 0, 0, 0, 0, 0,     32'h0000_1001, NOP,           1));
        vecs.push_back(mkv(AUI_OP, 0, 0, 0, 0, 0,     32'hFFFF_F000, 32'hFFFF_F017, 0));
        vecs.push_back(mkv(R_OP,   3, 1, 2, 0, 0,     32'd0,        32'h0020_81B3, 0));
        vecs.push_back(mkv(R_OP,   3, 1, 2, 0, 7'h20, 32'd0,        32'h4020_81B3, 0));
        vecs.push_back(mkv(5'b11111, 0, 0, 0, 0, 0,   32'd0,        NOP,           1));
        vecs.push_back(mkv(JR_OP,  0, 1, 0, 0, 0,     32'd0,        32'h0000_8067, 0));
        vecs.push_back(mkv(I_OP,   1, 0, 31, 0, 7'h7F, 32'd5,       32'h0050_0093, 0));

        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("reset_o_valid", o_valid, 0);
        checkOutput("reset_o_inst", o_inst, 0);
        checkOutput("reset_o_err", o_err, 0);
        checkOutput("reset_o_err_cnt", o_err_cnt, 0);
        checkOutput("reset_o_addr", o_addr, BASE);
        checkOutput("reset_o_ready", o_ready, 1);
        step();

        $display("[TB] table vectors");
        foreach (vecs[k]) applyStimulus(vecs[k]);
        drain();

        $display("[TB] stall: three bundles offered while i_ready=0");
        doFlush(1'b0);
        i_ready = 1'b0;
        start = accept_cnt;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            driveFields(vecs[idx]);
            i_valid = 1'b1;
            @(negedge i_clk);
            if (o_ready && idx < 2) idx++;
            step();
        end
        checkOutput("stall_accepts", accept_cnt - start, 2);
        i_valid = 1'b0;
        i_ready = 1'b1;
        applyStimulus(vecs[2]);
        drain();
        checkOutput("stall_total", accept_cnt - start, 3);

        $display("[TB] address wrap with five legal words");
        doFlush(1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(mkv(I_OP, 5'(k), 0, 0, 0, 0, 32'(k),
                                                     ref_encode(mkv(I_OP, 5'(k), 0, 0, 0, 0, 32'(k), 0, 0))[31:0], 0));
        drain();
        checkOutput("wrap_final_addr", o_addr, BASE + 32'd4);

        $display("[TB] flush with simultaneous i_valid");
        i_ready = 1'b0;
        applyStimulus(vecs[1]);
        applyStimulus(vecs[3]);
        start = accept_cnt;
        doFlush(1'b1);
        checkOutput("flush_refused", accept_cnt - start, 0);
        i_ready = 1'b1;
        applyStimulus(vecs[0]);
        drain();

        $display("[TB] reset with two words in flight");
        i_ready = 1'b0;
        applyStimulus(vecs[4]);
        applyStimulus(vecs[5]);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("midreset_o_valid", o_valid, 0);
        checkOutput("midreset_o_addr", o_addr, BASE);
        checkOutput("midreset_o_err_cnt", o_err_cnt, 0);
        step();
        i_ready = 1'b1;

        $display("[TB] random bundles");
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            v.op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 8)];
            v.rd  = 5'($urandom);
            v.rs1 = 5'($urandom);
            v.rs2 = 5'($urandom);
            v.f3  = 3'($urandom);
            v.f7  = 7'($urandom);
            v.imm = randImm();
            r = ref_encode(v);
            v.inst = r[31:0];
            v.err  = r[32];
            applyStimulus(v);
            if ($urandom_range(0, 4) == 0) step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
